// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the frame-state encoding, fixed line levels and the encoding
// that selects the source of the next serial bit.
package uart_tx_pkg;

    // Frame sequencer states. The encodings are explicit so that they stay
    // compatible with the legacy state values.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Fixed serial-line levels
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

    // Source of the next bit driven onto the serial line
    typedef enum logic [1:0] {
        SEL_START = 2'd0,
        SEL_DATA  = 2'd1,
        SEL_PAR   = 2'd2,
        SEL_STOP  = 2'd3
    } out_sel_t;

endpackage

// File: rtl/uart_tx_ctrl_serializer.sv
// Data latch, LSB-first shift register and bit counter for one UART frame.
//   clk, rst_n : TX clock, asynchronous active-low reset
//   load       : capture data_in and clear the bit counter
//   shift_en   : the current cycle drives a data bit; advance to the next one
//   data_in    : parallel word to serialize
//   ser_bit    : data bit to be driven on the line after the coming edge
//   ser_done   : the last data bit is the one currently on the line
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data_in;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
            // Saturate so the counter never wraps while sitting in DATA
            if (cnt != LAST_BIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The output pin is registered, so the top needs the bit one cycle ahead:
    // while shifting, the following bit is already at position 1.
    assign ser_bit  = shift_en ? shreg[1] : shreg[0];
    assign ser_done = (cnt == LAST_BIT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a parallel word with a valid strobe and
// drives one frame (start, data LSB-first, optional parity, stop) on TX_OUT,
// one bit per clock.
//   clk, rst_n : TX clock, asynchronous active-low reset
//   P_DATA     : word to send, sampled on acceptance
//   Data_Valid : request strobe, accepted while Busy is low (IDLE or STOP)
//   PAR_EN     : insert a parity bit, sampled on acceptance
//   PAR_TYP    : 1 = odd, 0 = even parity, sampled on acceptance
//   TX_OUT     : registered serial line, idle high
//   Busy       : registered; high from START through the last data/parity bit
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t state, next_state;
    out_sel_t  sel;
    logic      accept;
    logic      shift_en;
    logic      ser_bit;
    logic      ser_done;
    logic      par_en_q;
    logic      par_bit_q;
    logic      tx_next;
    logic      busy_next;

    // Busy is low in IDLE and STOP, so this also covers the stop-bit handoff
    assign accept   = Data_Valid && !Busy && ((state == IDLE) || (state == STOP));
    assign shift_en = (state == DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift_en (shift_en),
        .data_in  (P_DATA),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = accept ? START : IDLE;
            START:   next_state = DATA;
            DATA:    begin
                if (!ser_done) begin
                    next_state = DATA;
                end else if (par_en_q) begin
                    next_state = PARITY;
                end else begin
                    next_state = STOP;
                end
            end
            PARITY:  next_state = STOP;
            STOP:    next_state = accept ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they describe.
    always_comb begin
        sel = SEL_STOP;
        case (next_state)
            START:   sel = SEL_START;
            DATA:    sel = SEL_DATA;
            PARITY:  sel = SEL_PAR;
            default: sel = SEL_STOP;
        endcase
    end

    always_comb begin
        tx_next = IDLE_LINE;
        case (sel)
            SEL_START: tx_next = START_BIT;
            SEL_DATA:  tx_next = ser_bit;
            SEL_PAR:   tx_next = par_bit_q;
            SEL_STOP:  tx_next = (next_state == STOP) ? STOP_BIT : IDLE_LINE;
            default:   tx_next = IDLE_LINE;
        endcase
    end

    assign busy_next = (next_state == START) || (next_state == DATA) ||
                       (next_state == PARITY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            TX_OUT    <= IDLE_LINE;
            Busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_next;
            Busy   <= busy_next;
            if (accept) begin
                par_en_q  <= PAR_EN;
                // Even parity is the XOR of the data; odd parity inverts it
                par_bit_q <= (^P_DATA) ^ PAR_TYP;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with DATA_WIDTH = 8.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame vector: seq[0] is the first line bit after acceptance (start bit)
    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [0:10] seq;
        int          len;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Send one frame and compare every line cycle. Inputs are scrambled and a
    // refused 8'hFF request is pulsed while Busy is high.
    task automatic run_frame(input string nm, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [0:10] seq, input int len);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) Data_Valid = 1'b0;
            chk($sformatf("%s tx[%0d]", nm, i), TX_OUT, seq[i]);
            chk($sformatf("%s busy[%0d]", nm, i), Busy, (i < len - 1));
            if (i < len - 1) begin
                P_DATA  = ~P_DATA;
                PAR_TYP = ~PAR_TYP;
                PAR_EN  = ~PAR_EN;
            end
            if (i == 3) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
            end
            if (i == 4) Data_Valid = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("%s idle tx", nm), TX_OUT, 1'b1);
        chk($sformatf("%s idle busy", nm), Busy, 1'b0);
    endtask

    initial begin
        logic [0:10] b2b_a;
        logic [0:10] b2b_b;

        vecs[0] = '{"a5_nopar",   8'hA5, 1'b0, 1'b0, 11'b01010010111, 10};
        vecs[1] = '{"a5_even",    8'hA5, 1'b1, 1'b0, 11'b01010010101, 11};
        vecs[2] = '{"a5_odd",     8'hA5, 1'b1, 1'b1, 11'b01010010111, 11};
        vecs[3] = '{"01_odd",     8'h01, 1'b1, 1'b1, 11'b01000000001, 11};
        vecs[4] = '{"80_even",    8'h80, 1'b1, 1'b0, 11'b00000000111, 11};

        rst_n      = 1'b0;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset tx", TX_OUT, 1'b1);
        chk("reset busy", Busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset tx", TX_OUT, 1'b1);
        chk("post-reset busy", Busy, 1'b0);

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].name, vecs[v].data, vecs[v].par_en, vecs[v].par_typ,
                      vecs[v].seq, vecs[v].len);
        end

        // Back-to-back: second request issued during the stop bit
        b2b_a = 11'b01010010111;
        b2b_b = 11'b01111000011;
        @(negedge clk);
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) Data_Valid = 1'b0;
            chk($sformatf("b2b first tx[%0d]", i), TX_OUT, b2b_a[i]);
            chk($sformatf("b2b first busy[%0d]", i), Busy, (i < 9));
            if (i == 9) begin
                P_DATA     = 8'h0F;
                PAR_EN     = 1'b0;
                Data_Valid = 1'b1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) Data_Valid = 1'b0;
            chk($sformatf("b2b second tx[%0d]", i), TX_OUT, b2b_b[i]);
            chk($sformatf("b2b second busy[%0d]", i), Busy, (i < 9));
        end
        @(negedge clk);
        chk("b2b idle tx", TX_OUT, 1'b1);
        chk("b2b idle busy", Busy, 1'b0);

        // Asynchronous reset in the middle of the data bits
        @(negedge clk);
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", Busy, 1'b1);
        chk("pre-reset tx", TX_OUT, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset tx", TX_OUT, 1'b1);
        chk("async reset busy", Busy, 1'b0);
        @(negedge clk);
        chk("held reset tx", TX_OUT, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("released idle tx", TX_OUT, 1'b1);
        chk("released idle busy", Busy, 1'b0);
        run_frame("3c_after_reset", 8'h3C, 1'b0, 1'b0, 11'b00011110011, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
